// File: rtl/sequence_generator.sv
// sequence_generator: serial pattern transmitter.
// Accepts a WIDTH-bit pattern plus a repeat count over a valid/ready handshake and shifts
// the pattern out MSB-first, one bit per clock, rep+1 times back-to-back.
//
// Optional build macro SEQ_GEN_PARITY_EN: appends an even-parity bit (XOR of the pattern)
// after every repetition; done then coincides with the final parity bit.
//
// Ports:
//   clk        rising-edge clock
//   resetn     synchronous active-low reset
//   in_valid   request to transmit pattern/rep
//   in_ready   generator idle, can accept a request
//   pattern    bits to transmit, bit WIDTH-1 first
//   rep        extra repetitions (0 = send once)
//   dout       serial data bit (0 when dout_valid is low)
//   dout_valid dout carries a pattern bit this cycle
//   done       one-cycle pulse on the final bit of the final repetition
module sequence_generator #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned REP_W = 4
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] pattern,
  input  logic [REP_W-1:0] rep,
  output logic             dout,
  output logic             dout_valid,
  output logic             done
);

  // Position counts down from LastPos to 0 within one repetition.
`ifdef SEQ_GEN_PARITY_EN
  localparam int unsigned LastPos = WIDTH;
`else
  localparam int unsigned LastPos = WIDTH - 1;
`endif
  localparam int unsigned PosW = $clog2(LastPos + 1);

  typedef enum logic [0:0] {StIdle, StShift} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] pat_q, pat_d;
  logic [PosW-1:0]  pos_q, pos_d;
  logic [REP_W-1:0] rep_q, rep_d;
  logic             dout_q, dout_d;
  logic             valid_q, valid_d;
  logic             done_q, done_d;
  logic             ready_q, ready_d;

  // Bit presented at a given position; with parity, position 0 is the parity slot.
  function automatic logic bit_at(input logic [WIDTH-1:0] pat, input logic [PosW-1:0] pos);
    logic [WIDTH-1:0] sh;
    logic             res;
`ifdef SEQ_GEN_PARITY_EN
    sh  = pat >> (pos - PosW'(1));
    res = (pos == '0) ? ^pat : sh[0];
`else
    sh  = pat >> pos;
    res = sh[0];
`endif
    return res;
  endfunction

  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    pos_d   = pos_q;
    rep_d   = rep_q;
    dout_d  = 1'b0;
    valid_d = 1'b0;
    done_d  = 1'b0;
    ready_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          state_d = StShift;
          pat_d   = pattern;
          rep_d   = rep;
          pos_d   = PosW'(LastPos);
        end
      end
      StShift: begin
        if (pos_q != '0) begin
          pos_d = pos_q - PosW'(1);
        end else if (rep_q != '0) begin
          // Restart the word with no gap cycle.
          rep_d = rep_q - REP_W'(1);
          pos_d = PosW'(LastPos);
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // Outputs are registered: compute what the next cycle presents.
    if (state_d == StShift) begin
      dout_d  = bit_at(pat_d, pos_d);
      valid_d = 1'b1;
      done_d  = (pos_d == '0) && (rep_d == '0);
    end else begin
      ready_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= StIdle;
      pat_q   <= '0;
      pos_q   <= '0;
      rep_q   <= '0;
      dout_q  <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      pos_q   <= pos_d;
      rep_q   <= rep_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      ready_q <= ready_d;
    end
  end

  assign in_ready   = ready_q;
  assign dout       = dout_q;
  assign dout_valid = valid_q;
  assign done       = done_q;

endmodule

// File: tb/tb_sequence_generator.sv
// Scoreboard bench for sequence_generator: the driver pushes the expected serial stream
// of each accepted request; a forked monitor pops and compares on every valid output bit.
module tb_sequence_generator;

  localparam int unsigned W  = 4;
  localparam int unsigned RW = 4;
`ifdef SEQ_GEN_PARITY_EN
  localparam bit Par = 1'b1;
`else
  localparam bit Par = 1'b0;
`endif
  localparam int WordLen = W + (Par ? 1 : 0);

  logic          clk = 1'b0;
  logic          resetn;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  pattern;
  logic [RW-1:0] rep;
  logic          dout;
  logic          dout_valid;
  logic          done;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit in_xfer = 1'b0;

  typedef struct {
    logic b;
    logic d;
  } exp_t;
  exp_t sb[$];

  sequence_generator #(
    .WIDTH(W),
    .REP_W(RW)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .pattern   (pattern),
    .rep       (rep),
    .dout      (dout),
    .dout_valid(dout_valid),
    .done      (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b, expected %b (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Reference: the pattern MSB-first, rep+1 times, optional parity per word,
  // done on the last emitted bit.
  function automatic void push_model(input logic [W-1:0] p, input int r);
    exp_t e;
    for (int k = 0; k <= r; k++) begin
      for (int i = W - 1; i >= 0; i--) begin
        e.b = p[i];
        e.d = (k == r) && (i == 0) && !Par;
        sb.push_back(e);
      end
      if (Par) begin
        e.b = ^p;
        e.d = (k == r);
        sb.push_back(e);
      end
    end
  endfunction

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      check("ready_is_not_valid", in_ready, !dout_valid);
      if (dout_valid) begin
        if (sb.size() == 0) begin
          check("unexpected_bit", dout_valid, 1'b0);
        end else begin
          e = sb.pop_front();
          check("dout", dout, e.b);
          check("done", done, e.d);
          in_xfer = !e.d;
        end
      end else begin
        check("dout_idle", dout, 1'b0);
        check("done_idle", done, 1'b0);
        if (resetn) check("contiguous", in_xfer, 1'b0);
      end
      // The next edge resets the DUT: the pending stream is abandoned.
      if (!resetn) begin
        sb.delete();
        in_xfer = 1'b0;
      end
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the handshake edge.
  task automatic send(input logic [W-1:0] p, input logic [RW-1:0] r, output int acc);
    int n;
    n        = 0;
    acc      = -1;
    pattern  = p;
    rep      = r;
    in_valid = 1'b1;
    while (in_ready !== 1'b1 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (in_ready !== 1'b1) begin
      check("accept_timeout", in_ready, 1'b1);
      in_valid = 1'b0;
      return;
    end
    push_model(p, int'(r));
    @(posedge clk);
    #1;
    acc      = cyc;
    in_valid = 1'b0;
    check("first_bit_valid", dout_valid, 1'b1);
    check("first_bit_value", dout, p[W-1]);
    check("busy_not_ready", in_ready, 1'b0);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int c1, c2, n;
    logic [W-1:0] p;
    logic [RW-1:0] r;

    resetn   = 1'b0;
    in_valid = 1'b0;
    pattern  = '0;
    rep      = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_in_ready", in_ready, 1'b1);
    check("reset_dout_valid", dout_valid, 1'b0);
    check("reset_dout", dout, 1'b0);
    check("reset_done", done, 1'b0);
    resetn = 1'b1;
    fork
      monitor();
    join_none
    idle(1);

    // Single word, then a repeated word.
    send(4'b1010, 4'd0, c1);
    idle(WordLen + 2);
    send(4'b1010, 4'd1, c1);
    idle(2 * WordLen + 2);

    // Second request held through the first: accepted after exactly one idle cycle.
    send(4'b1010, 4'd0, c1);
    pattern  = 4'b1100;
    rep      = 4'd0;
    in_valid = 1'b1;
    send(4'b1100, 4'd0, c2);
    check_int("b2b_accept_gap", c2 - c1, WordLen + 1);
    idle(WordLen + 2);

    // Reset at the edge after the second bit aborts the word.
    send(4'b1010, 4'd0, c1);
    idle(1);
    resetn = 1'b0;
    idle(1);
    check("abort_dout_valid", dout_valid, 1'b0);
    check("abort_dout", dout, 1'b0);
    check("abort_done", done, 1'b0);
    check("abort_in_ready", in_ready, 1'b1);
    idle(1);
    resetn = 1'b1;
    idle(WordLen + 1);
    send(4'b0110, 4'd0, c1);
    idle(WordLen + 2);

    // Inputs changed after the handshake have no effect.
    send(4'b1011, 4'd0, c1);
    pattern = 4'b0000;
    rep     = 4'd3;
    idle(WordLen + 2);

    // Handshake on the same edge as reset is discarded.
    pattern  = 4'b1111;
    rep      = 4'd2;
    in_valid = 1'b1;
    resetn   = 1'b0;
    idle(1);
    in_valid = 1'b0;
    resetn   = 1'b1;
    idle(1);
    check("reset_hs_dropped", dout_valid, 1'b0);
    idle(4);

    // Maximum repeat count: 2^REP_W repetitions, no wrap.
    send(4'b1001, 4'd15, c1);
    idle(16 * WordLen + 2);

    // Randomized requests with random gaps.
    for (int k = 0; k < 25; k++) begin
      p = W'($urandom);
      r = ($urandom_range(0, 9) == 0) ? 4'd15 : RW'($urandom_range(0, 3));
      send(p, r, c1);
      if ($urandom_range(0, 1) == 1) begin
        // Random junk on the inputs while busy must be ignored.
        pattern  = W'($urandom);
        rep      = RW'($urandom);
        in_valid = 1'b1;
        idle(1);
        in_valid = 1'b0;
      end
      idle($urandom_range(0, 3));
    end

    n = 0;
    while ((sb.size() != 0 || dout_valid) && n < 300) begin
      idle(1);
      n++;
    end
    idle(3);
    check_int("scoreboard_drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
